// File: rtl/bitcoin_nonce_sched_pkg.sv
// Shared types and widths for the bitcoin nonce scheduler slice.
package bitcoin_pkg;

  localparam int NONCE_W = 32;
  localparam int ADDR_W  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } sched_state_t;

endpackage

// File: rtl/bitcoin_nonce_sched_if.sv
// Core-array handshake and result-memory write port of the nonce scheduler.
// master = scheduler side, slave = core array / memory side.
interface bitcoin_nonce_sched_if
  import bitcoin_pkg::*;
#(
  parameter int NUM_CORES = 8
);

  logic [NUM_CORES-1:0]              core_start;
  logic [NUM_CORES-1:0][NONCE_W-1:0] core_nonce;
  logic [NUM_CORES-1:0]              core_done;
  logic [NUM_CORES-1:0][NONCE_W-1:0] core_hash;
  logic                              mem_we;
  logic [ADDR_W-1:0]                 mem_addr;
  logic [NONCE_W-1:0]                mem_write_data;

  modport master (
    output core_start, core_nonce, mem_we, mem_addr, mem_write_data,
    input  core_done, core_hash
  );

  modport slave (
    input  core_start, core_nonce, mem_we, mem_addr, mem_write_data,
    output core_done, core_hash
  );

endinterface

// File: rtl/bitcoin_nonce_sched_nonce_result_buf.sv
// Per-core H0 capture registers plus the seen mask for the active batch.
// A core's word is captured only on its first done of the batch.
module nonce_result_buf
  import bitcoin_pkg::*;
#(
  parameter int NUM_CORES = 8,
  parameter int CNT_W     = $clog2(NUM_CORES + 1)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              clr,
  input  logic [NUM_CORES-1:0]              cap_en,
  input  logic [NUM_CORES-1:0][NONCE_W-1:0] cap_data,
  input  logic [CNT_W-1:0]                  rd_idx,
  output logic [NONCE_W-1:0]                rd_data,
  input  logic [CNT_W-1:0]                  n_act,
  output logic                              all_seen
);

  logic [NUM_CORES-1:0]              r_seen;
  logic [NUM_CORES-1:0][NONCE_W-1:0] r_data;
  logic [NUM_CORES-1:0]              w_act_mask;

  // Seen mask: cleared at batch launch, accumulates first dones.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    if (!reset_n) begin
      r_seen <= '0;
    end else if (clr) begin
      r_seen <= '0;
    end else begin
      r_seen <= r_seen | cap_en;
    end
  end

  // Capture storage: first done of each core wins.
  always_ff @(posedge clk) begin
    // NOTE: data registers carry no reset; r_seen gates every read, so stale contents are never used.
    for (int i = 0; i < NUM_CORES; i++) begin
      if (cap_en[i] && !r_seen[i] && !clr) begin
        r_data[i] <= cap_data[i];
      end
    end
  end

  // Read mux and batch-completion detect.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    rd_data    = '0;
    w_act_mask = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (rd_idx == CNT_W'(i)) rd_data = r_data[i];
      w_act_mask[i] = (CNT_W'(i) < n_act);
    end
    all_seen = ((r_seen & w_act_mask) == w_act_mask);
  end

endmodule

// File: rtl/bitcoin_nonce_sched.sv
// Bitcoin nonce scheduler: launches nonce batches across parallel SHA-256
// phase-3 cores, collects each core's H0 and writes them to memory at
// output_addr + nonce, then pulses done.
// Optional: define SCHED_CYCLE_CNT_EN to add the cycle_count output.
module bitcoin_nonce_sched
  import bitcoin_pkg::*;
#(
  parameter int NUM_NONCES = 16,
  parameter int NUM_CORES  = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    output_addr,
  output logic                 done,
  output logic                 mem_clk,
  bitcoin_nonce_sched_if.master bus
`ifdef SCHED_CYCLE_CNT_EN
  ,
  output logic [31:0]          cycle_count
`endif
);

  localparam int CNT_W = $clog2(NUM_CORES + 1);

  sched_state_t                      r_state;
  logic [ADDR_W-1:0]                 r_base;
  logic [ADDR_W-1:0]                 r_out_base;
  logic [ADDR_W-1:0]                 r_mem_addr;
  logic [CNT_W-1:0]                  r_n_act;
  logic [CNT_W-1:0]                  r_wr_idx;
  logic                              r_done;
  logic                              r_mem_we;
  logic [NONCE_W-1:0]                r_mem_data;
  logic [NUM_CORES-1:0]              r_core_start;
  logic [NUM_CORES-1:0][NONCE_W-1:0] r_core_nonce;

  logic [ADDR_W-1:0]    w_next_base;
  logic [ADDR_W-1:0]    w_launch_base;
  logic [CNT_W-1:0]     w_launch_n;
  logic [NUM_CORES-1:0] w_launch_mask;
  logic [NUM_CORES-1:0] w_act_mask;
  logic [NUM_CORES-1:0] w_cap_en;
  logic [CNT_W-1:0]     w_rd_idx;
  logic [NONCE_W-1:0]   w_rd_data;
  logic                 w_all_seen;
  logic                 w_last_batch;
  logic                 w_last_write;
  logic                 w_do_launch;

  // Cores used by a batch starting at base: min(NUM_CORES, NUM_NONCES - base).
  function automatic logic [CNT_W-1:0] calc_n_act(input logic [ADDR_W-1:0] base);
    logic [ADDR_W:0] rem;
    rem = (ADDR_W+1)'(NUM_NONCES) - {1'b0, base};
    if (rem >= (ADDR_W+1)'(NUM_CORES)) calc_n_act = CNT_W'(NUM_CORES);
    else                               calc_n_act = rem[CNT_W-1:0];
  endfunction

  // Batch bookkeeping, capture gating and write-side read index.
  always_comb begin
    w_next_base   = r_base + ADDR_W'(r_n_act);
    w_last_batch  = (({1'b0, r_base} + (ADDR_W+1)'(r_n_act)) == (ADDR_W+1)'(NUM_NONCES));
    w_last_write  = (r_wr_idx == (r_n_act - CNT_W'(1)));
    w_launch_base = (r_state == IDLE) ? '0 : w_next_base;
    w_launch_n    = calc_n_act(w_launch_base);
    w_launch_mask = '0;
    w_act_mask    = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_launch_mask[i] = (CNT_W'(i) < w_launch_n);
      w_act_mask[i]    = (CNT_W'(i) < r_n_act);
    end
    w_cap_en    = (r_state == WAIT) ? (bus.core_done & w_act_mask) : '0;
    // Outputs are registered, so WRITE fetches the entry for the next cycle.
    w_rd_idx    = (r_state == WRITE) ? (r_wr_idx + CNT_W'(1)) : '0;
    w_do_launch = ((r_state == IDLE) && start) ||
                  ((r_state == WRITE) && w_last_write && !w_last_batch);
  end

  nonce_result_buf #(
    .NUM_CORES (NUM_CORES),
    .CNT_W     (CNT_W)
  ) u_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (r_state == LAUNCH),
    .cap_en   (w_cap_en),
    .cap_data (bus.core_hash),
    .rd_idx   (w_rd_idx),
    .rd_data  (w_rd_data),
    .n_act    (r_n_act),
    .all_seen (w_all_seen)
  );

  // Scheduler FSM with registered launch, write and done outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_base       <= '0;
      r_out_base   <= '0;
      r_mem_addr   <= '0;
      r_n_act      <= '0;
      r_wr_idx     <= '0;
      r_done       <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_data   <= '0;
      r_core_start <= '0;
      r_core_nonce <= '0;
    end else begin
      r_core_start <= '0;
      r_mem_we     <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_out_base <= output_addr;
            r_base     <= '0;
            r_state    <= LAUNCH;
          end
        end
        LAUNCH: r_state <= WAIT;
        WAIT: begin
          if (w_all_seen) begin
            r_state    <= WRITE;
            r_wr_idx   <= '0;
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_out_base + r_base;
            r_mem_data <= w_rd_data;
          end
        end
        WRITE: begin
          if (w_last_write) begin
            if (w_last_batch) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_base  <= w_next_base;
              r_state <= LAUNCH;
            end
          end else begin
            r_wr_idx   <= r_wr_idx + CNT_W'(1);
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_mem_addr + ADDR_W'(1);
            r_mem_data <= w_rd_data;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_do_launch) begin
        r_n_act      <= w_launch_n;
        r_core_start <= w_launch_mask;
        for (int i = 0; i < NUM_CORES; i++) begin
          if (w_launch_mask[i]) r_core_nonce[i] <= NONCE_W'(w_launch_base) + NONCE_W'(i);
        end
      end
    end
  end

`ifdef SCHED_CYCLE_CNT_EN
  logic [31:0] r_cycle_count;

  // Run-length counter: cleared on start accept, saturating, frozen in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cycle_count <= '0;
    end else if (r_state == IDLE) begin
      if (start) r_cycle_count <= '0;
    end else if (r_cycle_count != '1) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  assign cycle_count = r_cycle_count;
`endif

  assign done               = r_done;
  assign mem_clk            = clk;
  assign bus.core_start     = r_core_start;
  assign bus.core_nonce     = r_core_nonce;
  assign bus.mem_we         = r_mem_we;
  assign bus.mem_addr       = r_mem_addr;
  assign bus.mem_write_data = r_mem_data;

endmodule

// File: tb/tb_bitcoin_nonce_sched.sv
// Directed bench for bitcoin_nonce_sched: a 16-nonce/8-core instance (dut_a)
// and a 10-nonce/4-core instance (dut_b), each driven by a small core model
// whose H0 is nonce ^ 32'hA5A5A5A5.
module tb_bitcoin_nonce_sched;
  import bitcoin_pkg::*;

  localparam int NC_A = 8;
  localparam int NN_A = 16;
  localparam int NC_B = 4;
  localparam int NN_B = 10;
  localparam logic [31:0] HMASK = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [15:0] addr_a = '0;
  logic [15:0] addr_b = '0;
  logic        done_a, done_b, mclk_a, mclk_b;
`ifdef SCHED_CYCLE_CNT_EN
  logic [31:0] cc_a, cc_b;
`endif

  int n_pass = 0;
  int n_checks = 0;

  bitcoin_nonce_sched_if #(.NUM_CORES(NC_A)) bus_a ();
  bitcoin_nonce_sched_if #(.NUM_CORES(NC_B)) bus_b ();

  bitcoin_nonce_sched #(.NUM_NONCES(NN_A), .NUM_CORES(NC_A)) dut_a (
    .clk(clk), .reset_n(rst_n), .start(start_a), .output_addr(addr_a),
    .done(done_a), .mem_clk(mclk_a), .bus(bus_a)
`ifdef SCHED_CYCLE_CNT_EN
    , .cycle_count(cc_a)
`endif
  );

  bitcoin_nonce_sched #(.NUM_NONCES(NN_B), .NUM_CORES(NC_B)) dut_b (
    .clk(clk), .reset_n(rst_n), .start(start_b), .output_addr(addr_b),
    .done(done_b), .mem_clk(mclk_b), .bus(bus_b)
`ifdef SCHED_CYCLE_CNT_EN
    , .cycle_count(cc_b)
`endif
  );

  always #5 clk = ~clk;

  // Core models: a core finishes dly cycles after its launch pulse.
  int                          dly_a[NC_A];
  int                          cnt_a[NC_A];
  logic [NC_A-1:0]             m_done_a = '0;
  logic [NC_A-1:0][31:0]       m_hash_a = '0;
  int                          dly_b[NC_B];
  int                          cnt_b[NC_B];
  logic [NC_B-1:0]             m_done_b = '0;
  logic [NC_B-1:0][31:0]       m_hash_b = '0;
  logic [NC_B-1:0]             stray_b = '0;
  logic [31:0]                 stray_hash_b = '0;
  logic [NC_B-1:0][31:0]       w_hash_b;

  always @(negedge clk) begin
    for (int i = 0; i < NC_A; i++) begin
      m_done_a[i] <= 1'b0;
      if (!rst_n) cnt_a[i] <= 0;
      else if (bus_a.core_start[i]) cnt_a[i] <= dly_a[i];
      else if (cnt_a[i] == 1) begin
        cnt_a[i]    <= 0;
        m_done_a[i] <= 1'b1;
        m_hash_a[i] <= bus_a.core_nonce[i] ^ HMASK;
      end else if (cnt_a[i] > 1) cnt_a[i] <= cnt_a[i] - 1;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NC_B; i++) begin
      m_done_b[i] <= 1'b0;
      if (!rst_n) cnt_b[i] <= 0;
      else if (bus_b.core_start[i]) cnt_b[i] <= dly_b[i];
      else if (cnt_b[i] == 1) begin
        cnt_b[i]    <= 0;
        m_done_b[i] <= 1'b1;
        m_hash_b[i] <= bus_b.core_nonce[i] ^ HMASK;
      end else if (cnt_b[i] > 1) cnt_b[i] <= cnt_b[i] - 1;
    end
  end

  always_comb begin
    w_hash_b = m_hash_b;
    for (int i = 0; i < NC_B; i++) if (stray_b[i]) w_hash_b[i] = stray_hash_b;
  end

  assign bus_a.core_done = m_done_a;
  assign bus_a.core_hash = m_hash_a;
  assign bus_b.core_done = m_done_b | stray_b;
  assign bus_b.core_hash = w_hash_b;

  // Monitors: record writes {addr,data}, launch masks and done cycles.
  logic [47:0]     wq_a[$];
  logic [47:0]     wq_b[$];
  logic [NC_A-1:0] lq_a[$];
  logic [NC_B-1:0] lq_b[$];
  int              dones_a = 0;
  int              dones_b = 0;

  always @(negedge clk) begin
    if (bus_a.mem_we) wq_a.push_back({bus_a.mem_addr, bus_a.mem_write_data});
    if (bus_b.mem_we) wq_b.push_back({bus_b.mem_addr, bus_b.mem_write_data});
    if (|bus_a.core_start) lq_a.push_back(bus_a.core_start);
    if (|bus_b.core_start) lq_b.push_back(bus_b.core_start);
    if (done_a) dones_a++;
    if (done_b) dones_b++;
  end

  // Expected memory entry for nonce n written relative to base.
  function automatic logic [47:0] exp_entry(input logic [15:0] base, input int n);
    logic [15:0] a;
    logic [31:0] d;
    a = base + 16'(n);
    d = 32'(n) ^ HMASK;
    return {a, d};
  endfunction

  function automatic logic [47:0] wq_a_at(input int idx);
    if (idx < wq_a.size()) return wq_a[idx];
    return 'x;
  endfunction

  function automatic logic [47:0] wq_b_at(input int idx);
    if (idx < wq_b.size()) return wq_b[idx];
    return 'x;
  endfunction

  task automatic set_dly_a(input int d);
    for (int i = 0; i < NC_A; i++) dly_a[i] = d;
  endtask

  task automatic pulse_start_a(input logic [15:0] a);
    @(negedge clk);
    addr_a  = a;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      cyc++;
      if (done_a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (done_a !== 1'b0) $display("FAIL reset_done: got %b want 0", done_a); else n_pass++;
    n_checks++; if (bus_a.mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", bus_a.mem_we); else n_pass++;
    n_checks++; if (bus_a.core_start !== '0) $display("FAIL reset_core_start: got %h want 0", bus_a.core_start); else n_pass++;
    n_checks++; if (bus_a.mem_addr !== 16'h0) $display("FAIL reset_mem_addr: got %h want 0", bus_a.mem_addr); else n_pass++;
    n_checks++; if (bus_a.mem_write_data !== 32'h0) $display("FAIL reset_mem_data: got %h want 0", bus_a.mem_write_data); else n_pass++;
    n_checks++; if (bus_a.core_nonce !== '0) $display("FAIL reset_core_nonce: got %h want 0", bus_a.core_nonce); else n_pass++;
    n_checks++; if (dut_a.r_state !== IDLE) $display("FAIL reset_state: got %0d want IDLE", dut_a.r_state); else n_pass++;
    n_checks++; if ({done_b, bus_b.mem_we, bus_b.core_start} !== '0) $display("FAIL reset_b_outputs: got %h want 0", {done_b, bus_b.mem_we, bus_b.core_start}); else n_pass++;
    n_checks++; if (mclk_a !== clk) $display("FAIL mem_clk: got %b want %b", mclk_a, clk); else n_pass++;
`ifdef SCHED_CYCLE_CNT_EN
    n_checks++; if (cc_a !== 32'h0) $display("FAIL reset_cycle_count: got %0d want 0", cc_a); else n_pass++;
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Full 16-nonce run at 0x0100, uniform core latency of 64.
  task automatic test_basic();
    int w0, l0, d0, cyc;
    bit ok;
    w0 = wq_a.size(); l0 = lq_a.size(); d0 = dones_a;
    set_dly_a(64);
    pulse_start_a(16'h0100);
    wait_done_a(1000, ok, cyc);
    n_checks++; if (!ok) $display("FAIL basic_timeout: done=0 after %0d cycles, want done=1", cyc); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (wq_a.size() - w0 !== 16) $display("FAIL basic_write_count: got %0d want 16", wq_a.size() - w0); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (wq_a_at(w0 + i) !== exp_entry(16'h0100, i))
        $display("FAIL basic_write[%0d]: got %h want %h", i, wq_a_at(w0 + i), exp_entry(16'h0100, i));
      else n_pass++;
    end
    n_checks++; if (lq_a.size() - l0 !== 2) $display("FAIL basic_launches: got %0d want 2", lq_a.size() - l0); else n_pass++;
    n_checks++; if (lq_a[l0] !== 8'hFF) $display("FAIL basic_launch_mask: got %h want ff", lq_a[l0]); else n_pass++;
    n_checks++; if (dones_a - d0 !== 1) $display("FAIL basic_done_cycles: got %0d want 1", dones_a - d0); else n_pass++;
  endtask

  // 10 nonces on 4 cores: batches 4,4,2; stray dones in the last batch.
  task automatic test_partial_batch();
    int w0, l0, d0, nl;
    bit ok;
    w0 = wq_b.size(); l0 = lq_b.size(); d0 = dones_b;
    dly_b[0] = 2;
    for (int i = 1; i < NC_B; i++) dly_b[i] = 8;
    @(negedge clk);
    addr_b  = 16'h0040;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    nl = 1;
    for (int c = 0; c < 200 && nl < 3; c++) begin
      @(negedge clk);
      if (|bus_b.core_start) nl++;
    end
    n_checks++; if (nl !== 3) $display("FAIL partial_third_launch: got %0d launches want 3", nl); else n_pass++;
    n_checks++;
    if (bus_b.core_nonce[0] !== 32'd8 || bus_b.core_nonce[1] !== 32'd9)
      $display("FAIL partial_nonces: got %0d,%0d want 8,9", bus_b.core_nonce[0], bus_b.core_nonce[1]);
    else n_pass++;
    // Core 0 has finished; re-pulse it with garbage and pulse unlaunched core 3.
    repeat (3) @(negedge clk);
    stray_b      = 4'b1001;
    stray_hash_b = 32'hDEADBEEF;
    @(negedge clk);
    stray_b = '0;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done_b) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) $display("FAIL partial_timeout: done=0 want done=1"); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (wq_b.size() - w0 !== 10) $display("FAIL partial_write_count: got %0d want 10", wq_b.size() - w0); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (wq_b_at(w0 + i) !== exp_entry(16'h0040, i))
        $display("FAIL partial_write[%0d]: got %h want %h", i, wq_b_at(w0 + i), exp_entry(16'h0040, i));
      else n_pass++;
    end
    n_checks++;
    if (lq_b.size() - l0 !== 3 || lq_b[l0] !== 4'hF || lq_b[l0+1] !== 4'hF || lq_b[l0+2] !== 4'h3)
      $display("FAIL partial_launch_masks: got n=%0d last=%h want n=3 masks f,f,3", lq_b.size() - l0, lq_b[lq_b.size()-1]);
    else n_pass++;
    n_checks++; if (dones_b - d0 !== 1) $display("FAIL partial_done_cycles: got %0d want 1", dones_b - d0); else n_pass++;
  endtask

  // Out-of-order and simultaneous core completion.
  task automatic test_out_of_order();
    int w0, cyc;
    bit ok;
    w0 = wq_a.size();
    dly_a[5] = 5;
    dly_a[0] = 10;
    for (int i = 1; i <= 4; i++) dly_a[i] = 15;
    dly_a[6] = 20;
    dly_a[7] = 20;
    pulse_start_a(16'h2000);
    wait_done_a(500, ok, cyc);
    n_checks++; if (!ok) $display("FAIL ooo_timeout: done=0 after %0d cycles want done=1", cyc); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (wq_a.size() - w0 !== 16) $display("FAIL ooo_write_count: got %0d want 16", wq_a.size() - w0); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (wq_a_at(w0 + i) !== exp_entry(16'h2000, i))
        $display("FAIL ooo_write[%0d]: got %h want %h", i, wq_a_at(w0 + i), exp_entry(16'h2000, i));
      else n_pass++;
    end
  endtask

  // Reset during the second batch's WRITE phase, then a clean rerun.
  task automatic test_reset_mid_write();
    int nw, w0, w1, cyc;
    bit ok;
    set_dly_a(3);
    pulse_start_a(16'h0300);
    nw = 0;
    for (int c = 0; c < 300 && nw < 10; c++) begin
      @(negedge clk);
      if (bus_a.mem_we) nw++;
    end
    n_checks++; if (nw !== 10) $display("FAIL midreset_reach_write: got %0d writes want 10", nw); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (bus_a.mem_we !== 1'b0) $display("FAIL midreset_mem_we: got %b want 0", bus_a.mem_we); else n_pass++;
    n_checks++; if (done_a !== 1'b0) $display("FAIL midreset_done: got %b want 0", done_a); else n_pass++;
    n_checks++; if (dut_a.r_state !== IDLE) $display("FAIL midreset_state: got %0d want IDLE", dut_a.r_state); else n_pass++;
    w1 = wq_a.size();
    repeat (4) @(negedge clk);
    n_checks++; if (wq_a.size() !== w1) $display("FAIL midreset_no_writes: got %0d extra writes want 0", wq_a.size() - w1); else n_pass++;
    rst_n = 1'b1;
    w0 = wq_a.size();
    pulse_start_a(16'h0300);
    wait_done_a(500, ok, cyc);
    n_checks++; if (!ok) $display("FAIL rerun_timeout: done=0 after %0d cycles want done=1", cyc); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (wq_a.size() - w0 !== 16) $display("FAIL rerun_write_count: got %0d want 16", wq_a.size() - w0); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (wq_a_at(w0 + i) !== exp_entry(16'h0300, i))
        $display("FAIL rerun_write[%0d]: got %h want %h", i, wq_a_at(w0 + i), exp_entry(16'h0300, i));
      else n_pass++;
    end
  endtask

  // start held high with a wrapping base address.
  task automatic test_start_held_wrap();
    int w0, l0, cyc;
    bit ok, relaunch;
    set_dly_a(4);
    w0 = wq_a.size(); l0 = lq_a.size();
    @(negedge clk);
    addr_a  = 16'hFFFC;
    start_a = 1'b1;
    wait_done_a(500, ok, cyc);
    n_checks++; if (!ok) $display("FAIL held_timeout: done=0 after %0d cycles want done=1", cyc); else n_pass++;
    n_checks++; if (lq_a.size() - l0 !== 2) $display("FAIL held_single_accept: got %0d launches want 2", lq_a.size() - l0); else n_pass++;
    relaunch = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (|bus_a.core_start) begin relaunch = 1'b1; break; end
    end
    n_checks++; if (!relaunch) $display("FAIL held_reaccept: launch=0 after done want launch=1"); else n_pass++;
    start_a = 1'b0;
    wait_done_a(500, ok, cyc);
    n_checks++; if (!ok) $display("FAIL held_second_timeout: done=0 after %0d cycles want done=1", cyc); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (wq_a.size() - w0 !== 32) $display("FAIL held_write_count: got %0d want 32", wq_a.size() - w0); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (wq_a_at(w0 + i) !== exp_entry(16'hFFFC, i))
        $display("FAIL held_write[%0d]: got %h want %h", i, wq_a_at(w0 + i), exp_entry(16'hFFFC, i));
      else n_pass++;
    end
  endtask

`ifdef SCHED_CYCLE_CNT_EN
  // cycle_count equals the number of non-IDLE cycles and holds after done.
  task automatic test_cycle_count();
    int cyc, meas;
    bit ok;
    set_dly_a(64);
    pulse_start_a(16'h0100);
    wait_done_a(1000, ok, cyc);
    meas = cyc + 1;
    n_checks++; if (!ok) $display("FAIL cc_timeout: done=0 want done=1"); else n_pass++;
    @(negedge clk);
    n_checks++; if (cc_a !== 32'(meas)) $display("FAIL cc_value: got %0d want %0d", cc_a, meas); else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++; if (cc_a !== 32'(meas)) $display("FAIL cc_hold: got %0d want %0d", cc_a, meas); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_partial_batch();
    test_out_of_order();
    test_reset_mid_write();
    test_start_held_wrap();
`ifdef SCHED_CYCLE_CNT_EN
    test_cycle_count();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
